// File: rtl/int_axi4l.sv
// int_axi4l: bridges a simple pulse-driven internal register bus onto an
// AXI4-Lite master. Only one transaction is outstanding at a time.
//
// Ports
//   m_axi_aclk / m_axi_aresetn : clock, asynchronous active-low reset
//   m_axi_aw* / m_axi_w* / m_axi_b* : AXI4-Lite write channels (master side)
//   m_axi_ar* / m_axi_r*            : AXI4-Lite read channels (master side)
//   int_addr, int_wr_data, int_wr_strb, int_wr_en, int_rd_en : request side;
//     the enables are single-cycle pulses, honoured only while idle
//   int_wr_ack/int_wr_err, int_rd_ack/int_rd_err : one-cycle completion
//     pulses; err is meaningful only together with its ack
//   int_rd_data : data of the most recent completed read
//   int_busy    : high whenever a transaction is in flight
module int_axi4l #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   int_addr,
  input  logic [DATA_WIDTH-1:0]   int_wr_data,
  input  logic [DATA_WIDTH/8-1:0] int_wr_strb,
  input  logic                    int_wr_en,
  input  logic                    int_rd_en,
  output logic                    int_wr_ack,
  output logic                    int_wr_err,
  output logic                    int_rd_ack,
  output logic                    int_rd_err,
  output logic [DATA_WIDTH-1:0]   int_rd_data,
  output logic                    int_busy
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_err_q, rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rd_data_d = rd_data_q;
    // Acks and errors are pulses: low unless a response lands this cycle.
    wr_ack_d  = 1'b0;
    wr_err_d  = 1'b0;
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Write wins a coincident request; the read pulse is simply lost.
        if (int_wr_en) begin
          addr_d    = int_addr;
          wdata_d   = int_wr_data;
          wstrb_d   = int_wr_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_ADDR_DATA;
        end else if (int_rd_en) begin
          addr_d    = int_addr;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; the next-state valids double
        // as the "still pending" flags so a same-cycle pair is handled.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_q && m_axi_bvalid) begin
          bready_d = 1'b0;
          wr_ack_d = 1'b1;
          wr_err_d = m_axi_bresp[1];
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && m_axi_rvalid) begin
          rready_d  = 1'b0;
          rd_data_d = m_axi_rdata;
          rd_ack_d  = 1'b1;
          rd_err_d  = m_axi_rresp[1];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  // Only one transaction is ever in flight, so AW and AR share the
  // captured address register.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign int_wr_ack    = wr_ack_q;
  assign int_wr_err    = wr_err_q;
  assign int_rd_ack    = rd_ack_q;
  assign int_rd_err    = rd_err_q;
  assign int_rd_data   = rd_data_q;
  assign int_busy      = busy_q;

endmodule
